// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART types and default frame constants
package spart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_STOP_BITS = 1;

endpackage

// File: rtl/transmitter.sv
// transmitter: double-buffered serial transmitter paced by an external baud tick
module transmitter
    import spart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int STOP_BITS = DEF_STOP_BITS,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 brg_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_load,
    input  logic                 clr_ovr,
    output logic                 TX,
    output logic                 TBR,
    output logic                 busy,
    output logic                 tx_ovr
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    tx_state_t            state, state_nxt;
    logic [DATA_BITS-1:0] hold_reg, hold_nxt, shift_reg, shift_nxt, shifted;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 hold_valid, hold_valid_nxt;
    logic                 tx_reg, tx_nxt;
    logic                 ovr, ovr_nxt;
    logic                 stop_cnt, stop_cnt_nxt;
    logic                 stop_last, start_frame;

    function automatic logic first_bit(input logic [DATA_BITS-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_BITS-1];
    endfunction

    assign shifted     = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
    assign stop_last   = (STOP_BITS == 1) | stop_cnt;
    assign start_frame = brg_en & hold_valid &
                         ((state == TX_IDLE) | ((state == TX_STOP) & stop_last));
    assign TX     = tx_reg;
    assign TBR    = ~hold_valid;
    assign busy   = (state != TX_IDLE);
    assign tx_ovr = ovr;

    // next-state: buffer writes, overrun flag and the per-tick frame sequencing
    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_reg;
        hold_valid_nxt = hold_valid;
        shift_nxt      = shift_reg;
        cnt_nxt        = cnt;
        stop_cnt_nxt   = stop_cnt;
        tx_nxt         = tx_reg;
        ovr_nxt        = (tx_load & hold_valid) | (ovr & ~clr_ovr);
        if (tx_load && !hold_valid) begin
            hold_nxt       = tx_data;
            hold_valid_nxt = 1'b1;
        end
        if (brg_en) begin
            case (state)
                TX_IDLE:  tx_nxt = 1'b1;
                TX_START: begin
                    tx_nxt    = first_bit(shift_reg);
                    cnt_nxt   = '0;
                    state_nxt = TX_DATA;
                end
                TX_DATA: begin
                    if (cnt < LAST) begin
                        shift_nxt = shifted;
                        tx_nxt    = first_bit(shifted);
                        cnt_nxt   = cnt + 1'b1;
                    end else begin
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (!stop_last) begin
                        stop_cnt_nxt = 1'b1;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = TX_IDLE;
                    end
                end
                default: state_nxt = TX_IDLE;
            endcase
        end
        if (start_frame) begin
            shift_nxt      = hold_reg;
            hold_valid_nxt = 1'b0;
            tx_nxt         = 1'b0;
            state_nxt      = TX_START;
        end
    end

    // all state registers; reset drives the line high at once and drops any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= TX_IDLE;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            cnt        <= '0;
            stop_cnt   <= 1'b0;
            tx_reg     <= 1'b1;
            ovr        <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_reg   <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            shift_reg  <= shift_nxt;
            cnt        <= cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            tx_reg     <= tx_nxt;
            ovr        <= ovr_nxt;
        end
    end

endmodule
